// File: rtl/nrisc_alu_pkg.sv
// nrisc_alu_pkg: shared op codes, flag bit positions and state encodings
// for the NRISC multi-cycle ALU.
package nrisc_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_NAND  = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SAR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_ROL   = 4'd9;
    localparam logic [3:0] OP_ROR   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    localparam int unsigned FLG_MINUS = 2;
    localparam int unsigned FLG_ZERO  = 1;
    localparam int unsigned FLG_CARRY = 0;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        HOLD
    } alu_state_e;

    // Iterative unit operation selector; ordering matches op codes 11..14.
    typedef enum logic [1:0] {
        MD_MUL,
        MD_MULHU,
        MD_DIVU,
        MD_REMU
    } md_kind_e;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/nrisc_alu_muldiv.sv
// nrisc_alu_muldiv: iterative unsigned shift-add multiplier and restoring
// divider, one bit per cycle. Loads on start, runs TAM steps, then pulses
// done for one cycle while result/carry are valid.
module nrisc_alu_muldiv
    import nrisc_alu_pkg::*;
#(
    parameter int unsigned TAM = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  md_kind_e       kind,
    input  logic [TAM-1:0] a,
    input  logic [TAM-1:0] b,
    output logic           done,
    output logic [TAM-1:0] result,
    output logic           carry
);

    localparam int unsigned CW = $clog2(TAM);
    localparam logic [CW-1:0] LAST = CW'(TAM - 1);

    md_kind_e       kind_q;
    logic [TAM-1:0] hi;      // product high half / partial remainder
    logic [TAM-1:0] lo;      // multiplier / dividend shifting into quotient
    logic [TAM-1:0] opd;     // multiplicand / divisor
    logic [CW-1:0]  cnt;
    logic           active;
    logic           div_zero;

    logic           is_mul;
    logic [TAM:0]   mul_sum;
    logic [TAM:0]   div_shift;
    logic           div_ge;
    logic [TAM-1:0] div_trial;

    // Per-step datapath for both the add-shift and the trial subtraction.
    always_comb begin
        is_mul    = (kind_q == MD_MUL) || (kind_q == MD_MULHU);
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opd : '0)};
        div_shift = {hi, lo[TAM-1]};
        div_ge    = (div_shift >= {1'b0, opd});
        // Only used when div_ge holds, where the true difference fits TAM bits.
        div_trial = div_shift[TAM-1:0] - opd;
    end

    // Operand load, iteration and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q   <= MD_MUL;
            hi       <= '0;
            lo       <= '0;
            opd      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                kind_q   <= kind;
                hi       <= '0;
                lo       <= a;
                opd      <= b;
                cnt      <= '0;
                active   <= 1'b1;
                div_zero <= (b == '0);
            end else if (active) begin
                if (is_mul) begin
                    hi <= mul_sum[TAM:1];
                    lo <= {mul_sum[0], lo[TAM-1:1]};
                end else begin
                    hi <= div_ge ? div_trial : div_shift[TAM-1:0];
                    lo <= {lo[TAM-2:0], div_ge};
                end
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Select the requested half and its carry flag.
    always_comb begin
        result = lo;
        carry  = |hi;
        case (kind_q)
            MD_MUL:   begin result = lo; carry = |hi;     end
            MD_MULHU: begin result = hi; carry = |hi;     end
            MD_DIVU:  begin result = lo; carry = div_zero; end
            MD_REMU:  begin result = hi; carry = div_zero; end
            default:  begin result = lo; carry = |hi;     end
        endcase
    end

endmodule

// File: rtl/nrisc_alu_mc.sv
// nrisc_alu_mc: multi-cycle NRISC execute-stage ALU with valid/ready
// handshakes on both sides. Single-cycle ops complete at the accepting edge;
// MUL/MULHU/DIVU/REMU use the iterative unit when NRISC_ALU_MULDIV_EN is
// defined, otherwise they behave as reserved single-cycle ops.
`ifndef TAM
`define TAM 32
`endif

module nrisc_alu_mc
    import nrisc_alu_pkg::*;
#(
    parameter int unsigned TAM = `TAM
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     op,
    input  logic [TAM-1:0] a,
    input  logic [TAM-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [TAM-1:0] result,
    output logic [2:0]     flags,
    output logic           busy
);

    localparam int unsigned SHW = $clog2(TAM);

    alu_state_e     state, state_nx;
    logic           accept, accept_sc, accept_md, md_op;
    logic           md_done, md_carry;
    logic [TAM-1:0] md_result;

    logic [TAM:0]   add_w, sub_w;
    logic [SHW-1:0] amt, amt_m1, amt_neg;
    logic           amt_nz;
    logic [TAM-1:0] sc_result;
    logic [2:0]     sc_flags;
    logic           sc_minus, sc_carry;

    assign in_ready  = (state != ITER) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign accept_sc = accept && !md_op;
    assign accept_md = accept && md_op;

`ifdef NRISC_ALU_MULDIV_EN
    logic [1:0] md_sel;

    assign md_op  = is_muldiv_op(op);
    assign md_sel = op[1:0] - 2'd3;
    assign busy   = (state == ITER);

    nrisc_alu_muldiv #(
        .TAM(TAM)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_md),
        .kind   (md_kind_e'(md_sel)),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result),
        .carry  (md_carry)
    );
`else
    assign md_op     = 1'b0;
    assign busy      = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign md_carry  = 1'b0;
`endif

    // Adder, logic unit and barrel shifter/rotator for single-cycle ops.
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        amt     = b[SHW-1:0];
        amt_nz  = (amt != '0);
        // Bit indices of the last bit shifted out; TAM-amt wraps to -amt mod TAM.
        amt_m1  = amt - SHW'(1);
        amt_neg = SHW'(0) - amt;

        sc_result = '0;
        sc_minus  = 1'b0;
        sc_carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = add_w[TAM-1:0];
                sc_carry  = add_w[TAM];
                sc_minus  = add_w[TAM-1] ^ ((a[TAM-1] == b[TAM-1]) && (add_w[TAM-1] != a[TAM-1]));
            end
            OP_SUB: begin
                sc_result = sub_w[TAM-1:0];
                sc_carry  = sub_w[TAM];
                sc_minus  = sub_w[TAM-1] ^ ((a[TAM-1] != b[TAM-1]) && (sub_w[TAM-1] != a[TAM-1]));
            end
            OP_AND:  sc_result = a & b;
            OP_NAND: sc_result = ~(a & b);
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_SHR: begin
                sc_result = a >> amt;
                sc_carry  = amt_nz & a[amt_m1];
            end
            OP_SAR: begin
                sc_result = $signed(a) >>> amt;
                sc_carry  = amt_nz & a[amt_m1];
            end
            OP_SHL: begin
                sc_result = a << amt;
                sc_carry  = amt_nz & a[amt_neg];
            end
            OP_ROL: begin
                sc_result = (a << amt) | (a >> amt_neg);
                sc_carry  = amt_nz & a[amt_neg];
            end
            OP_ROR: begin
                sc_result = (a >> amt) | (a << amt_neg);
                sc_carry  = amt_nz & a[amt_m1];
            end
            default: ;
        endcase

        sc_flags            = '0;
        sc_flags[FLG_MINUS] = sc_minus;
        sc_flags[FLG_ZERO]  = (sc_result == '0);
        sc_flags[FLG_CARRY] = sc_carry;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_md)      state_nx = ITER;
                else if (accept_sc) state_nx = HOLD;
            end
            HOLD: begin
                if (accept_md)      state_nx = ITER;
                else if (accept_sc) state_nx = HOLD;
                else if (out_ready) state_nx = IDLE;
            end
            ITER: begin
                if (md_done) state_nx = HOLD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output registers: load on single-cycle accept or iterative completion,
    // hold while the consumer stalls, drop valid once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (accept_sc) begin
            out_valid <= 1'b1;
            result    <= sc_result;
            flags     <= sc_flags;
        end else if ((state == ITER) && md_done) begin
            out_valid <= 1'b1;
            result    <= md_result;
            flags     <= {1'b0, (md_result == '0), md_carry};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nrisc_alu_mc.sv
// tb_nrisc_alu_mc: directed and randomized checks of nrisc_alu_mc (TAM=32)
// against an arithmetic reference model.
module tb_nrisc_alu_mc;

    localparam int unsigned TAM = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [TAM-1:0]  a;
    logic [TAM-1:0]  b;
    logic            out_valid;
    logic            out_ready;
    logic [TAM-1:0]  result;
    logic [2:0]      flags;
    logic            busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    nrisc_alu_mc #(
        .TAM(TAM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: returns {minus, zero, carry, result[31:0]}.
    function automatic logic [34:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        int          sh = int'(y[4:0]);
        logic [63:0] w;
        logic [31:0] r = '0;
        logic        c = 1'b0;
        logic        m = 1'b0;
        case (o)
            4'd0: begin w = 64'(x) + 64'(y); r = w[31:0]; c = w[32]; m = (sx + sy) < 0; end
            4'd1: begin r = x - y; c = (x < y); m = (sx - sy) < 0; end
            4'd2: r = x & y;
            4'd3: r = ~(x & y);
            4'd4: r = x | y;
            4'd5: r = x ^ y;
            4'd6: begin r = x >> sh; if (sh != 0) c = x[sh-1]; end
            4'd7: begin r = 32'($signed(x) >>> sh); if (sh != 0) c = x[sh-1]; end
            4'd8: begin r = x << sh; if (sh != 0) c = x[32-sh]; end
            4'd9: begin
                r = x;
                for (int k = 0; k < sh; k++) begin c = r[31]; r = {r[30:0], r[31]}; end
            end
            4'd10: begin
                r = x;
                for (int k = 0; k < sh; k++) begin c = r[0]; r = {r[0], r[31:1]}; end
            end
`ifdef NRISC_ALU_MULDIV_EN
            4'd11: begin w = 64'(x) * 64'(y); r = w[31:0];  c = |w[63:32]; end
            4'd12: begin w = 64'(x) * 64'(y); r = w[63:32]; c = |w[63:32]; end
            4'd13: begin if (y == 0) begin r = '1; c = 1'b1; end else r = x / y; end
            4'd14: begin if (y == 0) begin r = x;  c = 1'b1; end else r = x % y; end
`endif
            default: ;
        endcase
        return {m, (r == 0), c, r};
    endfunction

    function automatic int exp_latency(input logic [3:0] o);
`ifdef NRISC_ALU_MULDIV_EN
        if (o >= 4'd11 && o <= 4'd14) return TAM + 1;
`endif
        return 0;
    endfunction

    // Issue one op with out_ready=1, measure edges after the accepting edge
    // until out_valid, and check result/flags. Returns at the negedge where
    // out_valid was seen.
    task automatic run_one(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [34:0] e;
        int          w;
        int          lat;
        e = model(o, x, y);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); #1; w++; end
        if (!in_ready) chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({tag, "_lat"},    64'(lat),    64'(exp_latency(o)));
        chk({tag, "_result"}, 64'(result), 64'(e[31:0]));
        chk({tag, "_flags"},  64'(flags),  64'(e[34:32]));
    endtask

    logic [3:0]  bq_op  [8];
    logic [34:0] bq_exp [8];
    logic [31:0] held_r;
    logic [2:0]  held_f;
    logic [34:0] e;
    int          seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_flags",     64'(flags),     64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Directed vectors.
        run_one(4'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        chk("add_wrap_r", 64'(result), 64'h0);
        chk("add_wrap_f", 64'(flags),  64'b011);
        run_one(4'd1, 32'd3, 32'd5, "sub_neg");
        chk("sub_neg_r", 64'(result), 64'hFFFF_FFFE);
        chk("sub_neg_f", 64'(flags),  64'b101);
        run_one(4'd1, 32'h8000_0000, 32'd1, "sub_ovf");
        chk("sub_ovf_r", 64'(result), 64'h7FFF_FFFF);
        chk("sub_ovf_f", 64'(flags),  64'b100);
        run_one(4'd9, 32'h8000_0001, 32'd1, "rol1");
        chk("rol1_r", 64'(result), 64'h3);
        chk("rol1_f", 64'(flags),  64'b001);
        run_one(4'd6, 32'h1234_5678, 32'h20, "shr0");
        chk("shr0_r", 64'(result), 64'h1234_5678);
        chk("shr0_f", 64'(flags),  64'b000);
        run_one(4'd8, 32'hC000_0000, 32'd1, "shl1");
        run_one(4'd10, 32'h0000_0001, 32'd31, "ror31");
        run_one(4'd7, 32'h8000_0000, 32'd31, "sar31");
        run_one(4'd15, 32'h1234, 32'h5678, "rsvd");
        chk("rsvd_f", 64'(flags), 64'b010);

`ifdef NRISC_ALU_MULDIV_EN
        run_one(4'd11, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        chk("mul_ovf_r", 64'(result), 64'h0);
        chk("mul_ovf_f", 64'(flags),  64'b011);
        run_one(4'd13, 32'd7, 32'd0, "divu_z");
        chk("divu_z_r", 64'(result), 64'hFFFF_FFFF);
        chk("divu_z_f", 64'(flags),  64'b001);
        run_one(4'd14, 32'd100, 32'd7, "remu");
        chk("remu_r", 64'(result), 64'd2);
        run_one(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        run_one(4'd14, 32'd9, 32'd0, "remu_z");
`else
        run_one(4'd11, 32'd6, 32'd7, "op11_rsvd");
        chk("op11_rsvd_r", 64'(result), 64'h0);
        chk("op11_rsvd_f", 64'(flags),  64'b010);
`endif

        // Consumer stall: result/flags held, no new op accepted.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 32'h7FFF_FFFF; b = 32'd1;
        e = model(4'd0, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_valid",  64'(out_valid), 64'd1);
        chk("stall_result", 64'(result),    64'(e[31:0]));
        chk("stall_flags",  64'(flags),     64'(e[34:32]));
        held_r = result;
        held_f = flags;
        in_valid = 1'b1; op = 4'd5; a = 32'hFFFF; b = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", 64'(in_ready),  64'd0);
            chk("stall_hold_v",   64'(out_valid), 64'd1);
            chk("stall_hold_r",   64'(result),    64'(held_r));
            chk("stall_hold_f",   64'(flags),     64'(held_f));
        end

        // Back-to-back single-cycle ops with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            bq_op[i] = 4'($urandom_range(0, 10));
        end
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk("b2b_valid",  64'(out_valid), 64'd1);
                chk("b2b_result", 64'(result),    64'(bq_exp[i-1][31:0]));
                chk("b2b_flags",  64'(flags),     64'(bq_exp[i-1][34:32]));
            end
            if (i < 8) begin
                op = bq_op[i]; a = $urandom; b = $urandom;
                bq_exp[i] = model(op, a, b);
                in_valid = 1'b1;
                #1;
                chk("b2b_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Randomized ops across the whole op space.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  ro;
            logic [31:0] rx, ry;
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) rx = 32'($urandom_range(0, 3)) << 30;
            run_one(ro, rx, ry, "rnd");
        end

`ifdef NRISC_ALU_MULDIV_EN
        // Reset in the middle of a division aborts it without a result.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; op = 4'd13; a = $urandom; b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_stale", 64'(seen), 64'd0);
        run_one(4'd14, 32'd100, 32'd7, "post_abort_remu");
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
